// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter: FSM state encoding,
// response flag bit positions and a helper that packs the ALU flags.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int FLAGS_W   = 6;
  localparam int FLG_COUT  = 5;
  localparam int FLG_OFLOW = 4;
  localparam int FLG_ERR   = 3;
  localparam int FLG_E     = 2;
  localparam int FLG_G     = 1;
  localparam int FLG_L     = 0;

  // Place the individual ALU status bits at their fixed flag positions.
  function automatic logic [FLAGS_W-1:0] pack_flags(input logic cout,
                                                    input logic oflow,
                                                    input logic err,
                                                    input logic e,
                                                    input logic g,
                                                    input logic l);
    logic [FLAGS_W-1:0] f;
    f            = '0;
    f[FLG_COUT]  = cout;
    f[FLG_OFLOW] = oflow;
    f[FLG_ERR]   = err;
    f[FLG_E]     = e;
    f[FLG_G]     = g;
    f[FLG_L]     = l;
    return f;
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bundle of the request, response and ALU-side signals of the arbiter.
// slave: the arbiter's view. master: the surrounding environment
// (requesters, response sink and the ALU itself).
interface alu_req_arbiter_if #(
  parameter int WIDTH     = 4,
  parameter int CMD_WIDTH = 4,
  parameter int NUM_REQ   = 4
) ();
  import alu_arb_pkg::*;

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           REQ_VALID;
  logic [NUM_REQ-1:0]           REQ_READY;
  logic [NUM_REQ*WIDTH-1:0]     REQ_OPA;
  logic [NUM_REQ*WIDTH-1:0]     REQ_OPB;
  logic [NUM_REQ*CMD_WIDTH-1:0] REQ_CMD;
  logic [NUM_REQ-1:0]           REQ_MODE;
  logic [NUM_REQ-1:0]           REQ_CIN;

  logic                         RSP_VALID;
  logic                         RSP_READY;
  logic [ID_W-1:0]              RSP_ID;
  logic [2*WIDTH-1:0]           RSP_RES;
  logic [FLAGS_W-1:0]           RSP_FLAGS;

  logic [WIDTH-1:0]             ALU_OPA;
  logic [WIDTH-1:0]             ALU_OPB;
  logic [CMD_WIDTH-1:0]         ALU_CMD;
  logic                         ALU_MODE;
  logic                         ALU_CIN;
  logic                         ALU_CE;
  logic [1:0]                   ALU_INP_VALID;
  logic [2*WIDTH-1:0]           ALU_RES;
  logic                         ALU_COUT;
  logic                         ALU_OFLOW;
  logic                         ALU_ERR;
  logic                         ALU_E;
  logic                         ALU_G;
  logic                         ALU_L;

  modport slave (
    input  REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN,
    output REQ_READY,
    output RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS,
    input  RSP_READY,
    output ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_CE, ALU_INP_VALID,
    input  ALU_RES, ALU_COUT, ALU_OFLOW, ALU_ERR, ALU_E, ALU_G, ALU_L
  );

  modport master (
    output REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN,
    input  REQ_READY,
    input  RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS,
    output RSP_READY,
    input  ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_CE, ALU_INP_VALID,
    output ALU_RES, ALU_COUT, ALU_OFLOW, ALU_ERR, ALU_E, ALU_G, ALU_L
  );

endinterface

// File: rtl/alu_req_arbiter_rr_grant.sv
// Combinational round-robin picker: searches upward from last_grant+1,
// wrapping modulo NUM_REQ, and returns the first requesting index.
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] cand;

  // Walk the candidates in priority order; the first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ requesters. A round-robin winner's
// operands are registered onto the ALU ports, held for LAT cycles, and
// the ALU result is captured with the owner ID onto a valid/ready
// response channel.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CMD_WIDTH = 4,
  parameter int NUM_REQ   = 4,
  parameter int LAT       = 3
) (
  input logic              CLK,
  input logic              RST,
  alu_req_arbiter_if.slave bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  arb_state_e state_q, state_d;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] ready;
  logic               grant_fire;
  logic               capture;
  logic               release_rsp;

  logic [CNT_W-1:0]   cnt_q;
  logic [ID_W-1:0]    owner_q;
  logic [ID_W-1:0]    last_q;

  logic [WIDTH-1:0]     alu_opa_p0;
  logic [WIDTH-1:0]     alu_opb_p0;
  logic [CMD_WIDTH-1:0] alu_cmd_p0;
  logic                 alu_mode_p0;
  logic                 alu_cin_p0;
  logic                 alu_ce_p0;
  logic [1:0]           alu_iv_p0;

  logic                 rsp_vld_p1;
  logic [ID_W-1:0]      rsp_id_p1;
  logic [2*WIDTH-1:0]   rsp_res_p1;
  logic [FLAGS_W-1:0]   rsp_flags_p1;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr_grant (
    .req        (bus.REQ_VALID),
    .last_grant (last_q),
    .grant      (gnt_oh),
    .grant_idx  (gnt_idx),
    .grant_any  (gnt_any)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d     = state_q;
    ready       = '0;
    grant_fire  = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ready      = gnt_oh;
          grant_fire = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.RSP_READY) begin
          release_rsp = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latency counter, transaction owner and round-robin pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      owner_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      if (grant_fire) begin
        cnt_q   <= CNT_W'(LAT - 1);
        owner_q <= gnt_idx;
      end else if (state_q == BUSY && !capture) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (release_rsp) last_q <= owner_q;
    end
  end

  // Stage p0: winner's operands driven onto the ALU and held while busy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_opa_p0  <= '0;
      alu_opb_p0  <= '0;
      alu_cmd_p0  <= '0;
      alu_mode_p0 <= 1'b0;
      alu_cin_p0  <= 1'b0;
      alu_ce_p0   <= 1'b0;
      alu_iv_p0   <= 2'b00;
    end else if (grant_fire) begin
      alu_opa_p0  <= bus.REQ_OPA[int'(gnt_idx)*WIDTH +: WIDTH];
      alu_opb_p0  <= bus.REQ_OPB[int'(gnt_idx)*WIDTH +: WIDTH];
      alu_cmd_p0  <= bus.REQ_CMD[int'(gnt_idx)*CMD_WIDTH +: CMD_WIDTH];
      alu_mode_p0 <= bus.REQ_MODE[gnt_idx];
      alu_cin_p0  <= bus.REQ_CIN[gnt_idx];
      alu_ce_p0   <= 1'b1;
      alu_iv_p0   <= 2'b11;
    end else if (capture) begin
      alu_ce_p0 <= 1'b0;
      alu_iv_p0 <= 2'b00;
    end
  end

  // Stage p1: ALU result captured with its owner and offered as a response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_vld_p1   <= 1'b0;
      rsp_id_p1    <= '0;
      rsp_res_p1   <= '0;
      rsp_flags_p1 <= '0;
    end else if (capture) begin
      rsp_vld_p1   <= 1'b1;
      rsp_id_p1    <= owner_q;
      rsp_res_p1   <= bus.ALU_RES;
      rsp_flags_p1 <= pack_flags(bus.ALU_COUT, bus.ALU_OFLOW, bus.ALU_ERR,
                                 bus.ALU_E, bus.ALU_G, bus.ALU_L);
    end else if (release_rsp) begin
      rsp_vld_p1 <= 1'b0;
    end
  end

  // Accept is masked during reset so every output reads 0 while RST is high.
  assign bus.REQ_READY     = RST ? '0 : ready;
  assign bus.RSP_VALID     = rsp_vld_p1;
  assign bus.RSP_ID        = rsp_id_p1;
  assign bus.RSP_RES       = rsp_res_p1;
  assign bus.RSP_FLAGS     = rsp_flags_p1;
  assign bus.ALU_OPA       = alu_opa_p0;
  assign bus.ALU_OPB       = alu_opb_p0;
  assign bus.ALU_CMD       = alu_cmd_p0;
  assign bus.ALU_MODE      = alu_mode_p0;
  assign bus.ALU_CIN       = alu_cin_p0;
  assign bus.ALU_CE        = alu_ce_p0;
  assign bus.ALU_INP_VALID = alu_iv_p0;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios followed by random
// transactions, with a behavioural ALU stub and a round-robin model.
module tb_alu_req_arbiter;

  localparam int W   = 4;
  localparam int CW  = 4;
  localparam int N   = 4;
  localparam int LAT = 3;

  logic CLK = 1'b0;
  logic RST;
  int   cyc    = 0;
  int   total  = 0;
  int   passes = 0;
  int   fails  = 0;
  int   last;

  logic [W-1:0]  opa [N];
  logic [W-1:0]  opb [N];
  logic [CW-1:0] cmd [N];
  logic [N-1:0]  vld, mode, cin;

  logic [13:0] alu_p0 = '0;
  logic [13:0] alu_p1 = '0;

  alu_req_arbiter_if #(.WIDTH(W), .CMD_WIDTH(CW), .NUM_REQ(N)) bus ();

  alu_req_arbiter #(.WIDTH(W), .CMD_WIDTH(CW), .NUM_REQ(N), .LAT(LAT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Small ALU: returns {RES[7:0], COUT, OFLOW, ERR, E, G, L}.
  function automatic logic [13:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic m,
                                        input logic ci, input logic [1:0] iv);
    logic [7:0] r;
    logic [4:0] s;
    logic co, ov, er, e, g, l;
    r = '0; s = '0; co = 0; ov = 0; er = 0; e = 0; g = 0; l = 0;
    if (iv != 2'b11) er = 1'b1;
    else if (m) begin
      case (c)
        4'd0: begin s = {1'b0, a} + {1'b0, b}; r = {3'b0, s}; co = s[4]; end
        4'd1: begin r = {4'b0, a} - {4'b0, b}; ov = (a < b); end
        4'd2: begin s = {1'b0, a} + {1'b0, b} + {4'b0, ci}; r = {3'b0, s}; co = s[4]; end
        4'd8: begin e = (a == b); g = (a > b); l = (a < b); end
        4'd9: r = {4'b0, a} * {4'b0, b};
        default: er = 1'b1;
      endcase
    end else begin
      case (c)
        4'd0: r = {4'b0, a & b};
        4'd1: r = {4'b0, a | b};
        4'd2: r = {4'b0, a ^ b};
        4'd3: r = {4'b0, ~a};
        default: er = 1'b1;
      endcase
    end
    return {r, co, ov, er, e, g, l};
  endfunction

  // ALU stand-in: result settles LAT-1 edges after the operands change.
  always @(posedge CLK) begin
    alu_p0 <= bus.ALU_CE ? alu_f(bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD, bus.ALU_MODE,
                                 bus.ALU_CIN, bus.ALU_INP_VALID) : 14'h0;
    alu_p1 <= alu_p0;
  end
  assign bus.ALU_RES   = alu_p1[13:6];
  assign bus.ALU_COUT  = alu_p1[5];
  assign bus.ALU_OFLOW = alu_p1[4];
  assign bus.ALU_ERR   = alu_p1[3];
  assign bus.ALU_E     = alu_p1[2];
  assign bus.ALU_G     = alu_p1[1];
  assign bus.ALU_L     = alu_p1[0];

  // Round-robin rule: first valid index after the last owner, wrapping.
  function automatic int pick(input logic [N-1:0] m, input int lst);
    for (int k = 1; k <= N; k++) begin
      if (m[(lst + k) % N]) return (lst + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.REQ_VALID = vld;
    bus.REQ_MODE  = mode;
    bus.REQ_CIN   = cin;
    for (int i = 0; i < N; i++) begin
      bus.REQ_OPA[i*W +: W]   = opa[i];
      bus.REQ_OPB[i*W +: W]   = opb[i];
      bus.REQ_CMD[i*CW +: CW] = cmd[i];
    end
  endtask

  task automatic rand_req(input int i);
    opa[i]  = 4'($urandom);
    opb[i]  = 4'($urandom);
    cmd[i]  = 4'($urandom);
    mode[i] = 1'($urandom);
    cin[i]  = 1'($urandom);
  endtask

  // One full transaction starting just after a rising edge in IDLE.
  task automatic txn(input int stall, input bit drop, output int w,
                     output logic [15:0] rsp);
    logic [13:0] e;
    logic [16:0] hold;
    int acc, n;
    bit got;
    @(negedge CLK);
    chk("idle_rsp_valid", 64'(bus.RSP_VALID), 64'(0));
    w = pick(bus.REQ_VALID, last);
    chk("req_ready", 64'(bus.REQ_READY), (w < 0) ? 64'(0) : (64'(1) << w));
    if (w < 0) w = 0;
    e    = alu_f(opa[w], opb[w], cmd[w], mode[w], cin[w], 2'b11);
    hold = {opa[w], opb[w], cmd[w], mode[w], cin[w], 1'b1, 2'b11};
    @(posedge CLK); #1;
    acc = cyc;
    if (drop) vld[w] = 1'b0;
    rand_req(w);
    apply();
    bus.RSP_READY = (stall == 0);
    n = 0; got = 0;
    while (!got && n < LAT + 3) begin
      @(negedge CLK);
      n++;
      if (n == 1)
        chk("alu_hold", 64'({bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD, bus.ALU_MODE,
                             bus.ALU_CIN, bus.ALU_CE, bus.ALU_INP_VALID}), 64'(hold));
      if (bus.RSP_VALID) got = 1;
      else chk("busy_ready", 64'(bus.REQ_READY), 64'(0));
    end
    chk("latency", 64'(cyc - acc), 64'(LAT));
    rsp = {bus.RSP_ID, bus.RSP_RES, bus.RSP_FLAGS};
    chk("rsp_id", 64'(bus.RSP_ID), 64'(w));
    chk("rsp_res", 64'(bus.RSP_RES), 64'(e[13:6]));
    chk("rsp_flags", 64'(bus.RSP_FLAGS), 64'(e[5:0]));
    chk("alu_released", 64'({bus.ALU_CE, bus.ALU_INP_VALID}), 64'(0));
    for (int s = 0; s < stall; s++) begin
      @(negedge CLK);
      chk("stall_hold", 64'({bus.RSP_VALID, bus.REQ_READY, bus.RSP_ID, bus.RSP_RES,
                             bus.RSP_FLAGS}), 64'({1'b1, 4'b0000, rsp}));
    end
    bus.RSP_READY = 1'b1;
    @(posedge CLK); #1;
    bus.RSP_READY = 1'b0;
    last = w;
  endtask

  initial begin
    int w;
    logic [15:0] rsp;
    RST = 1'b1;
    last = N - 1;
    for (int i = 0; i < N; i++) rand_req(i);
    vld = 4'hF;
    apply();
    bus.RSP_READY = 1'b0;

    // Reset state, with all requests asserted.
    #12;
    chk("reset_outputs", 64'({bus.REQ_READY, bus.RSP_VALID, bus.RSP_ID, bus.RSP_RES,
                              bus.RSP_FLAGS, bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD,
                              bus.ALU_MODE, bus.ALU_CIN, bus.ALU_CE, bus.ALU_INP_VALID}),
        64'(0));
    @(posedge CLK); #1;
    RST = 1'b0;

    // All requesters continuously valid: IDs rotate 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      txn(0, 1'b0, w, rsp);
      chk("rr_rotation", 64'(rsp[15:14]), 64'(k % N));
    end

    // Requester 2 alone: 5 + 3 in arithmetic mode.
    vld = 4'b0100;
    opa[2] = 4'd5; opb[2] = 4'd3; cmd[2] = 4'd0; mode[2] = 1'b1; cin[2] = 1'b0;
    apply();
    txn(0, 1'b1, w, rsp);
    chk("add_5_3", 64'(rsp), 64'({2'd2, 8'd8, 6'b000000}));

    // Requester 3 compares equal operands.
    vld = 4'b1000;
    opa[3] = 4'h7; opb[3] = 4'h7; cmd[3] = 4'd8; mode[3] = 1'b1; cin[3] = 1'b0;
    apply();
    txn(0, 1'b1, w, rsp);
    chk("cmp_equal", 64'(rsp), 64'({2'd3, 8'd0, 6'b000100}));

    // Requester 1: F + 1 carries out.
    vld = 4'b0010;
    opa[1] = 4'hF; opb[1] = 4'h1; cmd[1] = 4'd0; mode[1] = 1'b1; cin[1] = 1'b0;
    apply();
    txn(0, 1'b1, w, rsp);
    chk("add_carry", 64'(rsp), 64'({2'd1, 8'h10, 6'b100000}));

    // Response stalled 10 cycles while requester 0 waits; it follows at once.
    vld = 4'b0101;
    apply();
    txn(10, 1'b1, w, rsp);
    chk("stall_owner", 64'(rsp[15:14]), 64'(2));
    txn(0, 1'b1, w, rsp);
    chk("after_stall_owner", 64'(rsp[15:14]), 64'(0));

    // Illegal command: ERR passes through, arbitration continues.
    vld = 4'b0010;
    opa[1] = 4'h3; opb[1] = 4'h4; cmd[1] = 4'hF; mode[1] = 1'b1;
    apply();
    txn(0, 1'b1, w, rsp);
    chk("err_flag", 64'({rsp[15:14], rsp[3]}), 64'({2'd1, 1'b1}));
    vld = 4'b0001;
    apply();
    txn(1, 1'b1, w, rsp);

    // Reset pulsed mid-transaction.
    vld = 4'b0010;
    apply();
    @(negedge CLK);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("async_reset", 64'({bus.REQ_READY, bus.RSP_VALID, bus.RSP_ID, bus.RSP_RES,
                            bus.RSP_FLAGS, bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD,
                            bus.ALU_MODE, bus.ALU_CIN, bus.ALU_CE, bus.ALU_INP_VALID}),
        64'(0));
    @(posedge CLK); #1;
    RST = 1'b0;
    last = N - 1;
    vld = 4'b1001;
    apply();
    txn(0, 1'b1, w, rsp);
    chk("post_reset_pri", 64'(rsp[15:14]), 64'(0));
    txn(0, 1'b1, w, rsp);
    chk("post_reset_req3", 64'(rsp[15:14]), 64'(3));

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      vld = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) rand_req(i);
      apply();
      txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w, rsp);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
